// File: rtl/arbmux.sv
// rtl/arbmux.sv - N-channel round-robin arbiter/mux with registered output stage.
// Optional packet locking enabled by defining ARBMUX_LOCK_EN.
module arbmux #(
  parameter int W = 32,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [N-1:0]   out_grant,
  input  logic           out_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic          out_last_q;
  logic [N-1:0]  out_grant_q;

  logic          load;
  logic          xfer;
  logic          found;
  logic [N-1:0]  eligible;
  logic [N-1:0]  winner;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] next_ptr;
  logic [W-1:0]  sel_data;
  logic          sel_last;

`ifdef ARBMUX_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_e;
  lock_state_e  state_q, state_d;
  logic [N-1:0] lock_mask_q, lock_mask_d;

  // While mid-packet only the locked channel may win.
  assign eligible = (state_q == LOCKED) ? (in_valid & lock_mask_q) : in_valid;
`else
  assign eligible = in_valid;
`endif

  assign load = !out_valid_q || out_ready;

  always_comb begin
    int idx;
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int j = 0; j < N; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= N) idx = idx - N;
      if (!found && eligible[PW'(idx)]) begin
        winner[PW'(idx)] = 1'b1;
        win_idx          = PW'(idx);
        found            = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*W +: W] & {W{winner[i]}});
      sel_last = sel_last | (in_last[i] & winner[i]);
    end
  end

  assign in_ready = (load && !rst) ? winner : '0;
  assign xfer     = load && !rst && found;
  assign next_ptr = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);

  always_comb begin
    ptr_d = ptr_q;
`ifdef ARBMUX_LOCK_EN
    state_d     = state_q;
    lock_mask_d = lock_mask_q;
    if (xfer) begin
      if (sel_last) begin
        state_d = IDLE;
        ptr_d   = next_ptr;
      end else begin
        state_d     = LOCKED;
        lock_mask_d = winner;
      end
    end
`else
    if (xfer) ptr_d = next_ptr;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_grant_q <= '0;
`ifdef ARBMUX_LOCK_EN
      state_q     <= IDLE;
      lock_mask_q <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
`ifdef ARBMUX_LOCK_EN
      state_q     <= state_d;
      lock_mask_q <= lock_mask_d;
`endif
      if (load) begin
        out_valid_q <= found;
        // Payload holds its last value when nothing is granted.
        if (found) begin
          out_data_q  <= sel_data;
          out_last_q  <= sel_last;
          out_grant_q <= winner;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_grant = out_grant_q;

endmodule

// File: tb/tb_arbmux.sv
// tb/tb_arbmux.sv - randomized and directed self-checking bench for arbmux (N=4, W=8).
module tb_arbmux;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   vin;
  logic [N*W-1:0] din;
  logic [N-1:0]   lin;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [N-1:0]   out_grant;
  logic           ordy;

  int tests = 0;
  int fails = 0;

  // Reference state: what the output register and arbitration pointer must hold.
  logic         m_ov = 1'b0;
  logic [W-1:0] m_od = '0;
  logic         m_ol = 1'b0;
  logic [N-1:0] m_og = '0;
  int           m_ptr = 0;
  int           m_lock = -1;

  arbmux #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(vin), .in_data(din), .in_last(lin), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_grant(out_grant), .out_ready(ordy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int j = 0; j < N; j++) begin
      int c;
      c = (m_ptr + j) % N;
      if (vin[c] && (m_lock < 0 || m_lock == c)) return c;
    end
    return -1;
  endfunction

  // Inputs are already driven (just after a falling edge); runs one clock.
  task automatic step();
    int k;
    logic ld;
    logic [N-1:0] er;
    ld = !m_ov || ordy;
    k  = pick();
    er = (rst || !ld || k < 0) ? '0 : N'(1 << k);
    #1 chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (rst) begin
      m_ov = 0; m_od = '0; m_ol = 0; m_og = '0; m_ptr = 0; m_lock = -1;
    end else if (ld) begin
      if (k < 0) m_ov = 0;
      else begin
        m_ov = 1; m_od = din[k*W +: W]; m_ol = lin[k]; m_og = N'(1 << k);
`ifdef ARBMUX_LOCK_EN
        if (lin[k]) begin m_lock = -1; m_ptr = (k + 1) % N; end
        else m_lock = k;
`else
        m_ptr = (k + 1) % N;
`endif
      end
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_last", 32'(out_last), 32'(m_ol));
    chk("out_grant", 32'(out_grant), 32'(m_og));
  endtask

  task automatic do_reset();
    rst = 1; vin = '0; lin = '0; ordy = 0;
    step();
    rst = 0;
  endtask

  initial begin
    logic [N-1:0] g5 [5];
    logic [W-1:0] d5 [5];
    logic [N-1:0] g4 [4];
    g5 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    d5 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    rst = 1; vin = '0; din = '0; lin = '0; ordy = 0;
    @(negedge clk);
    do_reset();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_grant", 32'(out_grant), 32'd0);

    din = {8'h13, 8'h12, 8'h11, 8'h10};
    vin = 4'b1111; lin = 4'b1111; ordy = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rot_grant", 32'(out_grant), 32'(g5[i]));
      chk("rot_data", 32'(out_data), 32'(d5[i]));
    end

    do_reset();
    vin = 4'b1000; ordy = 1;
    #1 chk("single_ready", 32'(in_ready), 32'h8);
    step();
    chk("single_data", 32'(out_data), 32'h13);
    chk("single_grant", 32'(out_grant), 32'h8);
    vin = 4'b1111;
    step();
    chk("ptr_wrap_grant", 32'(out_grant), 32'h1);

    do_reset();
    vin = 4'b1111; ordy = 1;
    step();
    ordy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", 32'(in_ready), 32'h0);
      chk("stall_grant", 32'(out_grant), 32'h1);
      chk("stall_data", 32'(out_data), 32'h10);
    end
    ordy = 1;
    #1 chk("resume_ready", 32'(in_ready), 32'h2);
    step();
    chk("resume_grant", 32'(out_grant), 32'h2);

    rst = 1;
    step();
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_grant", 32'(out_grant), 32'h0);
    rst = 0; vin = 4'b0110;
    step();
    chk("postrst_grant", 32'(out_grant), 32'h2);

    do_reset();
    vin = 4'b0001; lin = 4'b1111; ordy = 1;
    step();
`ifdef ARBMUX_LOCK_EN
    g4 = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
`else
    g4 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    vin = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      lin = {2'b11, (i == 2) ? 1'b1 : 1'b0, 1'b1};
      step();
      chk("pkt_grant", 32'(out_grant), 32'(g4[i]));
    end

`ifdef ARBMUX_LOCK_EN
    do_reset();
    vin = 4'b0010; lin = 4'b0000; ordy = 1;
    step();
    vin = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      #1 chk("locked_ready", 32'(in_ready), 32'h0);
      step();
    end
    vin = 4'b0111; lin = 4'b0010;
    #1 chk("unlock_ready", 32'(in_ready), 32'h2);
    step();
`endif

    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      vin  = N'($urandom);
      din  = (N*W)'($urandom);
      lin  = N'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
